// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with a registered 3-bit grant index,
// back-to-back handover and a hold-time limit that forces rotation.
// `release` is a reserved word in SystemVerilog, so the holder-done input is named holder_release.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       holder_release,
  output logic       grant_valid,
  output logic [2:0] grant_idx,
  output logic       preempt
);

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [7:0] hold_cnt;

  logic [7:0] others;
  logic       withdraw;
  logic       timeout;
  logic       leave;

  // The scan runs from the farthest offset down to the nearest, so the
  // set bit closest to `start` is the one that sticks.
  function automatic logic [2:0] pick(input logic [7:0] mask, input logic [2:0] start);
    logic [2:0] idx;
    pick = start;
    for (int off = 7; off >= 0; off--) begin
      idx = start + 3'(off);
      if (mask[idx]) pick = idx;
    end
  endfunction

  // NOTE: combinational decode uses blocking assignments; the state register below uses only <=.
  always_comb begin
    others   = req & ~(8'b1 << grant_idx);
    withdraw = ~req[grant_idx];
    timeout  = (hold_cnt == HOLD_MAX) && (others != 8'b0);
    leave    = holder_release | withdraw | timeout;
  end

  assign grant_valid = (state == BUSY);

  // NOTE: every register, outputs included, is cleared by the asynchronous reset; there is no memory here to leave uninitialised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_idx <= 3'd0;
      ptr       <= 3'd0;
      hold_cnt  <= 8'd0;
      preempt   <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 8'b0) begin
            state     <= BUSY;
            grant_idx <= pick(req, ptr);
            hold_cnt  <= 8'd1;
          end
        end
        BUSY: begin
          if (leave) begin
            ptr     <= grant_idx + 3'd1;
            preempt <= timeout & ~holder_release & ~withdraw;
            if (others != 8'b0) begin
              // Old holder is masked so the handover has no bubble and is fair.
              grant_idx <= pick(others, grant_idx + 3'd1);
              hold_cnt  <= 8'd1;
            end else begin
              state <= IDLE;
            end
          end else if (hold_cnt < HOLD_MAX) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed scenarios plus randomized
// traffic against a rule-level reference model, on two MAX_HOLD settings.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       rel;

  logic       gv0, pr0, gv1, pr1;
  logic [2:0] gi0, gi1;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  rr_arbiter_8 #(.MAX_HOLD(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .holder_release(rel),
    .grant_valid(gv0), .grant_idx(gi0), .preempt(pr0)
  );

  rr_arbiter_8 #(.MAX_HOLD(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .holder_release(rel),
    .grant_valid(gv1), .grant_idx(gi1), .preempt(pr1)
  );

  // Reference model: one entry per DUT, state kept as plain integers.
  int m_hold [2] = '{16, 4};
  int m_valid[2];
  int m_idx  [2];
  int m_ptr  [2];
  int m_cnt  [2];
  int m_pre  [2];

  function automatic int first_from(input int mask, input int start);
    for (int off = 0; off < 8; off++)
      if (mask & (1 << ((start + off) % 8))) return (start + off) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 0; m_idx[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0; m_pre[d] = 0;
    end
  endtask

  task automatic model_step(input int r, input int rl);
    int others, wd, to;
    for (int d = 0; d < 2; d++) begin
      m_pre[d] = 0;
      if (m_valid[d] == 0) begin
        if (r != 0) begin
          m_valid[d] = 1; m_idx[d] = first_from(r, m_ptr[d]); m_cnt[d] = 1;
        end
      end else begin
        others = r & ~(1 << m_idx[d]) & 255;
        wd = ((r >> m_idx[d]) & 1) == 0;
        to = (m_cnt[d] == m_hold[d]) && (others != 0);
        if (rl || wd || to) begin
          m_pre[d] = to && !rl && !wd;
          m_ptr[d] = (m_idx[d] + 1) % 8;
          if (others != 0) begin
            m_idx[d] = first_from(others, (m_idx[d] + 1) % 8); m_cnt[d] = 1;
          end else begin
            m_valid[d] = 0;
          end
        end else if (m_cnt[d] < m_hold[d]) begin
          m_cnt[d] = m_cnt[d] + 1;
        end
      end
    end
  endtask

  // Advance one clock with the current inputs; returns 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    model_step(int'(req), int'(rel));
    #1;
  endtask

  task automatic do_reset();
    req = 8'h00; rel = 1'b0; rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req = 8'h00; rel = 1'b0; rst_n = 1'b0;
    model_reset();
    #12;
    tests_run++; if ({gv0, gi0, pr0} !== 5'b0) begin tests_failed++; $display("FAIL reset_initial got=%b want=00000", {gv0, gi0, pr0}); end
    @(negedge clk); rst_n = 1'b1;
    req = 8'hFF;
    step(); step(); step();
    tests_run++; if (gv0 !== 1'b1 || gi0 !== 3'd0) begin tests_failed++; $display("FAIL reset_pre_grant got=%b/%0d want=1/0", gv0, gi0); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    tests_run++; if ({gv0, gi0, pr0} !== 5'b0) begin tests_failed++; $display("FAIL reset_async got=%b want=00000", {gv0, gi0, pr0}); end
    @(negedge clk); rst_n = 1'b1;
    step();
    tests_run++; if (gv0 !== 1'b1 || gi0 !== 3'd0) begin tests_failed++; $display("FAIL reset_first_grant got=%b/%0d want=1/0", gv0, gi0); end
  endtask

  task automatic test_single();
    req = 8'h00; step();
    tests_run++; if (gv0 !== 1'b0) begin tests_failed++; $display("FAIL single_idle got=%b want=0", gv0); end
    req = 8'h20; step();
    tests_run++; if (gv0 !== 1'b1 || gi0 !== 3'd5) begin tests_failed++; $display("FAIL single_grant got=%b/%0d want=1/5", gv0, gi0); end
    rel = 1'b1; step(); rel = 1'b0;
    tests_run++; if (gv0 !== 1'b0 || gi0 !== 3'd5) begin tests_failed++; $display("FAIL single_bubble got=%b/%0d want=0/5", gv0, gi0); end
    step();
    tests_run++; if (gv0 !== 1'b1 || gi0 !== 3'd5) begin tests_failed++; $display("FAIL single_regrant got=%b/%0d want=1/5", gv0, gi0); end
  endtask

  task automatic test_rotation();
    do_reset();
    req = 8'hFF; step();
    tests_run++; if (gv0 !== 1'b1 || gi0 !== 3'd0) begin tests_failed++; $display("FAIL rot_start got=%b/%0d want=1/0", gv0, gi0); end
    for (int k = 0; k < 9; k++) begin
      rel = 1'b0; step();
      rel = 1'b1; step();
      tests_run++;
      if (gv0 !== 1'b1 || gi0 !== 3'((k + 1) % 8) || gv1 !== 1'b1 || gi1 !== 3'((k + 1) % 8)) begin
        tests_failed++; $display("FAIL rot_order k=%0d got=%0d/%0d want=%0d", k, gi0, gi1, (k + 1) % 8);
      end
    end
    rel = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    req = 8'h03;
    for (int c = 0; c < 4; c++) begin
      step();
      tests_run++; if (gv1 !== 1'b1 || gi1 !== 3'd0 || pr1 !== 1'b0) begin tests_failed++; $display("FAIL to_hold c=%0d got=%b/%0d/%b want=1/0/0", c, gv1, gi1, pr1); end
    end
    step();
    tests_run++; if (gi1 !== 3'd1 || pr1 !== 1'b1) begin tests_failed++; $display("FAIL to_preempt got=%0d/%b want=1/1", gi1, pr1); end
    req = 8'h01;
    for (int c = 0; c < 20; c++) begin
      step();
      tests_run++; if (gv1 !== 1'b1 || gi1 !== 3'd0 || pr1 !== 1'b0) begin tests_failed++; $display("FAIL to_lone c=%0d got=%b/%0d/%b want=1/0/0", c, gv1, gi1, pr1); end
    end
  endtask

  task automatic test_withdraw_wrap();
    do_reset();
    req = 8'h80; step();
    req = 8'h81; step();
    tests_run++; if (gi0 !== 3'd7) begin tests_failed++; $display("FAIL wrap_holder got=%0d want=7", gi0); end
    req = 8'h01; step();
    tests_run++; if (gv0 !== 1'b1 || gi0 !== 3'd0 || pr0 !== 1'b0) begin tests_failed++; $display("FAIL wrap_handover got=%b/%0d/%b want=1/0/0", gv0, gi0, pr0); end
    do_reset();
    req = 8'h03;
    for (int c = 0; c < 4; c++) step();
    rel = 1'b1; step(); rel = 1'b0;
    tests_run++; if (gi1 !== 3'd1 || pr1 !== 1'b0) begin tests_failed++; $display("FAIL rel_and_timeout got=%0d/%b want=1/0", gi1, pr1); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      if ($urandom_range(0, 7) == 0) req = 8'h00;
      rel = ($urandom_range(0, 5) == 0);
      step();
      tests_run++;
      if (gv0 !== m_valid[0][0] || gi0 !== 3'(m_idx[0]) || pr0 !== m_pre[0][0]) begin
        tests_failed++; $display("FAIL rand_mh16 c=%0d got=%b/%0d/%b want=%0d/%0d/%0d", c, gv0, gi0, pr0, m_valid[0], m_idx[0], m_pre[0]);
      end
      tests_run++;
      if (gv1 !== m_valid[1][0] || gi1 !== 3'(m_idx[1]) || pr1 !== m_pre[1][0]) begin
        tests_failed++; $display("FAIL rand_mh4 c=%0d got=%b/%0d/%b want=%0d/%0d/%0d", c, gv1, gi1, pr1, m_valid[1], m_idx[1], m_pre[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_withdraw_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
